// File: rtl/debug_pkg.sv
// Shared types and constants for the debug-word framing path.
package debug_pkg;

   localparam int          DBG_WORD_W    = 32;
   localparam logic [7:0]  DBG_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CSUM} dbg_tx_state_e;

endpackage

// File: rtl/debug_trig_gen.sv
// Periodic auto-trigger timer merged with the external capture request.
// Produces a single combined trigger pulse; coincident sources collapse into one.
module debug_trig_gen #(
   parameter int PERIOD = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic trig_i,
   output logic trig_o
);

   logic tick;

   generate
      if (PERIOD > 0) begin : g_timer
         localparam int            TW   = $clog2(PERIOD + 1);
         localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

         logic [TW-1:0] cnt_q;

         always_ff @(posedge clk) begin
            if (rst)
               cnt_q <= '0;
            else if (cnt_q == LAST)
               cnt_q <= '0;
            else
               cnt_q <= cnt_q + TW'(1);
         end

         assign tick = (cnt_q == LAST);
      end else begin : g_no_timer
         assign tick = 1'b0;
      end
   endgenerate

   assign trig_o = trig_i | tick;

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots the debug words on a trigger and streams them as
// sync byte, payload (word 0 first, MSB first), XOR checksum over valid/ready.
module debug_frame_tx
   import debug_pkg::*;
#(
   parameter int         NUM_WORDS = 3,
   parameter int         PERIOD    = 0,
   parameter logic [7:0] SYNC_BYTE = DBG_SYNC_BYTE
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_WORDS-1:0][DBG_WORD_W-1:0]  dbg_words_i,
   input  logic                                  trig_i,
   output logic [7:0]                            tx_data_o,
   output logic                                  tx_vld_o,
   input  logic                                  tx_rdy_i,
   output logic                                  busy_o,
   output logic [15:0]                           frame_cnt_o,
   output logic [15:0]                           drop_cnt_o
);

   localparam int            NB   = 4 * NUM_WORDS;
   localparam int            IW   = $clog2(NB);
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   dbg_tx_state_e       state_q;
   logic [NB-1:0][7:0]  snap_q, snap_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [7:0]          csum_q;
   logic [7:0]          tx_data_q;
   logic                tx_vld_q;
   logic                busy_q;
   logic [15:0]         frame_cnt_q;
   logic [15:0]         drop_cnt_q;
   logic                trig;
   logic                hs;

   debug_trig_gen #(.PERIOD(PERIOD)) u_trig_gen (
      .clk    (clk),
      .rst    (rst),
      .trig_i (trig_i),
      .trig_o (trig)
   );

   // Snapshot stored in transmit order, so byte k of the payload is simply snap_q[k].
   always_comb begin
      snap_d = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         for (int b = 0; b < 4; b++) begin
            snap_d[4*w + b] = dbg_words_i[w][8*(3-b) +: 8];
         end
      end
   end

   assign idx_d = idx_q + IW'(1);
   assign hs    = tx_vld_q & tx_rdy_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         idx_q       <= '0;
         csum_q      <= '0;
         tx_data_q   <= '0;
         tx_vld_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (trig && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF))
            drop_cnt_q <= drop_cnt_q + 16'd1;

         case (state_q)
            IDLE: begin
               if (trig) begin
                  snap_q    <= snap_d;
                  idx_q     <= '0;
                  csum_q    <= '0;
                  tx_data_q <= SYNC_BYTE;
                  tx_vld_q  <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= SYNC;
               end
            end
            SYNC: begin
               if (hs) begin
                  tx_data_q <= snap_q[0];
                  state_q   <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (hs) begin
                  csum_q <= csum_q ^ tx_data_q;
                  if (idx_q == LAST) begin
                     tx_data_q <= csum_q ^ tx_data_q;
                     state_q   <= CSUM;
                  end else begin
                     idx_q     <= idx_d;
                     tx_data_q <= snap_q[idx_d];
                  end
               end
            end
            CSUM: begin
               if (hs) begin
                  tx_data_q   <= '0;
                  tx_vld_q    <= 1'b0;
                  busy_q      <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data_o   = tx_data_q;
   assign tx_vld_o    = tx_vld_q;
   assign busy_o      = busy_q;
   assign frame_cnt_o = frame_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Self-checking bench for debug_frame_tx: vector table, hand sequences,
// random frames against a byte-list model, and a periodic-timer instance.
module tb_debug_frame_tx;

   localparam int NW = 3;
   localparam int FL = 4 * NW + 2;

   typedef struct {
      logic [NW-1:0][31:0] w;
      int                  pct;
      int                  chg_at;
      logic [7:0]          csum;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 rst_t = 1'b1;
   logic [NW-1:0][31:0]  words_a, words_b;
   logic                 trig_a, rdy_a;
   logic [7:0]           data_a, data_b;
   logic                 vld_a, vld_b, busy_a, busy_b;
   logic [15:0]          fc_a, fc_b, dc_a, dc_b;
   logic                 trig_b = 1'b0;
   logic                 rdy_b  = 1'b1;

   int ncmp = 0;
   int nerr = 0;
   int ncyc;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   int   b_rise[5];
   int   b_nrise = 0;
   logic [15:0] b_fc115, b_dc115;
   logic b_done = 1'b0;

   always #5 clk = ~clk;

   debug_frame_tx #(.NUM_WORDS(NW), .PERIOD(0)) dut_a (
      .clk(clk), .rst(rst), .dbg_words_i(words_a), .trig_i(trig_a),
      .tx_data_o(data_a), .tx_vld_o(vld_a), .tx_rdy_i(rdy_a),
      .busy_o(busy_a), .frame_cnt_o(fc_a), .drop_cnt_o(dc_a));

   debug_frame_tx #(.NUM_WORDS(NW), .PERIOD(20)) dut_b (
      .clk(clk), .rst(rst_t), .dbg_words_i(words_b), .trig_i(trig_b),
      .tx_data_o(data_b), .tx_vld_o(vld_b), .tx_rdy_i(rdy_b),
      .busy_o(busy_b), .frame_cnt_o(fc_b), .drop_cnt_o(dc_b));

   function automatic logic [NW-1:0][31:0] mk(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c);
      return {c, b, a};
   endfunction

   // Expected frame: sync, each word's bytes high to low, then XOR of payload bytes.
   function automatic void build_frame(input logic [NW-1:0][31:0] w);
      logic [7:0] cs;
      logic [7:0] b;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      cs = 8'h00;
      for (int i = 0; i < 4 * NW; i++) begin
         b = 8'((w[i / 4] >> (8 * (3 - (i % 4)))) & 32'hFF);
         exp_q.push_back(b);
         cs = cs ^ b;
      end
      exp_q.push_back(cs);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_frame(input string name);
      int bad;
      bad = -1;
      ncmp++;
      if (got_q.size() != exp_q.size()) bad = 0;
      else
         for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
         nerr++;
         if (got_q.size() != exp_q.size())
            $display("FAIL %s: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
         else
            $display("FAIL %s: byte %0d got %0h expected %0h", name, bad, got_q[bad], exp_q[bad]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_trig();
      trig_a = 1'b1;
      tick();
      trig_a = 1'b0;
      chk("sync latency busy", 32'(busy_a), 1);
      chk("sync latency vld", 32'(vld_a), 1);
      chk("sync latency data", 32'(data_a), 32'hA5);
   endtask

   // Entered with the sync byte on offer; collects handshaken bytes until the checksum goes.
   task automatic run_frame(input int pct, input int chg_at);
      logic v, hs, prev_stall, done;
      logic [7:0] d, prev_d;
      int stall_err;
      prev_stall = 1'b0;
      prev_d     = 8'h00;
      done       = 1'b0;
      stall_err  = 0;
      ncyc       = 0;
      got_q.delete();
      for (int c = 0; c < 600 && !done; c++) begin
         rdy_a = ($urandom_range(99) < pct);
         @(negedge clk);
         v = vld_a;
         d = data_a;
         if (prev_stall && (!v || d !== prev_d)) stall_err++;
         hs = v && rdy_a;
         if (hs) got_q.push_back(d);
         if (hs && chg_at > 0 && got_q.size() == chg_at) words_a = '1;
         prev_stall = v && !rdy_a;
         prev_d     = d;
         tick();
         ncyc++;
         if (hs && got_q.size() == FL) done = 1'b1;
      end
      rdy_a = 1'b0;
      if (!done) begin
         ncmp++;
         nerr++;
         $display("FAIL frame timeout: got %0d bytes expected %0d", got_q.size(), FL);
      end
      chk("stall stable", 32'(stall_err), 0);
      chk("busy after csum", 32'(busy_a), 0);
      chk("vld after csum", 32'(vld_a), 0);
   endtask

   // Periodic instance: record the edge after which busy rises, counting edges out of reset.
   initial begin
      logic pb;
      pb = 1'b0;
      @(negedge rst_t);
      for (int e = 1; e <= 118; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy_b && !pb && b_nrise < 5) begin
            b_rise[b_nrise] = e;
            b_nrise++;
         end
         pb = busy_b;
         if (e == 115) begin
            b_fc115 = fc_b;
            b_dc115 = dc_b;
         end
      end
      b_done = 1'b1;
   end

   initial begin
      vec_t vecs[5];
      logic [15:0] fc0, dc0;
      vecs[0] = '{mk(32'h0000000C, 32'h000000FF, 32'h00C74FD7), 100, 0, 8'hAC};
      vecs[1] = '{mk(32'h0000000C, 32'h000000FF, 32'h00C74FD7),  30, 0, 8'hAC};
      vecs[2] = '{mk(32'h0000000C, 32'h000000FF, 32'h00C74FD7), 100, 6, 8'hAC};
      vecs[3] = '{mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF),  50, 0, 8'h00};
      vecs[4] = '{mk(32'h80000000, 32'h00000100, 32'h00000000),  70, 3, 8'h81};

      rst     = 1'b1;
      trig_a  = 1'b0;
      rdy_a   = 1'b0;
      words_a = vecs[0].w;
      words_b = vecs[0].w;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b0;
      rst_t = 1'b0;
      tick();
      chk("reset vld", 32'(vld_a), 0);
      chk("reset data", 32'(data_a), 0);
      chk("reset busy", 32'(busy_a), 0);
      chk("reset frame_cnt", 32'(fc_a), 0);
      chk("reset drop_cnt", 32'(dc_a), 0);

      for (int i = 0; i < 5; i++) begin
         words_a = vecs[i].w;
         build_frame(vecs[i].w);
         fc0 = fc_a;
         do_trig();
         run_frame(vecs[i].pct, vecs[i].chg_at);
         cmp_frame($sformatf("vector %0d frame", i));
         chk($sformatf("vector %0d csum", i), 32'(got_q.size() == FL ? got_q[FL-1] : 8'hxx),
             32'(vecs[i].csum));
         chk($sformatf("vector %0d frame_cnt", i), 32'(fc_a), 32'(fc0 + 16'd1));
         if (vecs[i].pct == 100)
            chk($sformatf("vector %0d cycles", i), 32'(ncyc), FL);
      end

      // Drops during a frame and on the checksum handshake, then back-to-back restart.
      words_a = vecs[0].w;
      build_frame(words_a);
      dc0 = dc_a;
      fc0 = fc_a;
      do_trig();
      rdy_a = 1'b1;
      got_q.delete();
      for (int t = 0; t < FL; t++) begin
         trig_a = (t == 2 || t == 5 || t == 8 || t == FL - 1);
         @(negedge clk);
         if (vld_a) got_q.push_back(data_a);
         tick();
      end
      trig_a = 1'b0;
      rdy_a  = 1'b0;
      cmp_frame("drop frame");
      chk("drop count", 32'(dc_a), 32'(dc0 + 16'd4));
      chk("drop frame_cnt", 32'(fc_a), 32'(fc0 + 16'd1));
      chk("drop busy", 32'(busy_a), 0);
      do_trig();
      run_frame(100, 0);
      cmp_frame("restart frame");
      chk("restart drop count", 32'(dc_a), 32'(dc0 + 16'd4));

      // Reset in the middle of the payload.
      do_trig();
      rdy_a = 1'b1;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      rdy_a = 1'b0;
      chk("midreset vld", 32'(vld_a), 0);
      chk("midreset busy", 32'(busy_a), 0);
      chk("midreset data", 32'(data_a), 0);
      chk("midreset frame_cnt", 32'(fc_a), 0);
      chk("midreset drop_cnt", 32'(dc_a), 0);
      build_frame(words_a);
      do_trig();
      run_frame(60, 0);
      cmp_frame("post-reset frame");
      chk("post-reset frame_cnt", 32'(fc_a), 1);

      for (int r = 0; r < 15; r++) begin
         words_a = mk($urandom, $urandom, $urandom);
         build_frame(words_a);
         fc0 = fc_a;
         do_trig();
         run_frame($urandom_range(20, 100), 0);
         cmp_frame($sformatf("random frame %0d", r));
         chk($sformatf("random frame_cnt %0d", r), 32'(fc_a), 32'(fc0 + 16'd1));
      end

      for (int c = 0; c < 500 && !b_done; c++) tick();
      chk("timer monitor done", 32'(b_done), 1);
      chk("timer rises", 32'(b_nrise), 5);
      for (int k = 0; k < 5; k++)
         if (k < b_nrise)
            chk($sformatf("timer frame %0d start", k), 32'(b_rise[k]), 32'(20 * (k + 1)));
      chk("timer frame_cnt", 32'(b_fc115), 5);
      chk("timer drop_cnt", 32'(b_dc115), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
